// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic {NORMAL, LOCKED} st_t;
    localparam int PORT_CORE = 0;
    localparam int PORT_DBG = 1;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_MAX_STARVE = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core, debug and memory-side signals of the arbiter
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic c_req;
    logic c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic c_gnt;
    logic c_rvalid;
    logic [DW-1:0] c_rdata;
    logic d_req;
    logic d_we;
    logic d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic d_gnt;
    logic d_rvalid;
    logic [DW-1:0] d_rdata;
    logic mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input c_req, c_we, c_addr, c_wdata, d_req, d_we, d_lock, d_addr, d_wdata, mem_rdata,
        output c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_lock, d_addr, d_wdata, mem_rdata,
        input c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_resp.sv
// mem_arb_resp: registered read response (data held between responses)
module mem_arb_resp import mem_arb_pkg::*; #(
    parameter int DW = DEF_DW
) (
    input logic clk,
    input logic rst,
    input logic rd,
    input logic [DW-1:0] mem_rdata,
    output logic rvalid,
    output logic [DW-1:0] rdata
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata <= '0;
        end else begin
            rvalid <= rd;
            if (rd) rdata <= mem_rdata;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between core and debug with starvation bound and debug lock
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int DW = DEF_DW,
    parameter int MAX_STARVE = DEF_MAX_STARVE
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_STARVE + 1);
    st_t st, st_nxt;
    logic [SW-1:0] starve, starve_nxt;
    logic sat, c_gnt, d_gnt;
    logic [1:0] rd, rv;
    logic [DW-1:0] rdt [2];
    assign sat = starve == SW'(MAX_STARVE);
    always_ff @(posedge clk) begin
        if (!rst) begin
            st <= NORMAL;
            starve <= '0;
        end else begin
            st <= st_nxt;
            starve <= starve_nxt;
        end
    end
    // The lock is held while d_lock stays high; a grant in the releasing cycle still happens.
    always_comb begin
        d_gnt = st == LOCKED ? bus.d_req : bus.d_req && (sat || !bus.c_req);
        c_gnt = st == NORMAL && bus.c_req && !(bus.d_req && sat);
        st_nxt = (st == LOCKED || d_gnt) && bus.d_lock ? LOCKED : NORMAL;
        starve_nxt = (!bus.d_req || d_gnt) ? '0 : (c_gnt && !sat) ? starve + 1'b1 : starve;
    end
    assign bus.c_gnt = c_gnt;
    assign bus.d_gnt = d_gnt;
    assign bus.mem_we = c_gnt ? bus.c_we : d_gnt && bus.d_we;
    assign bus.mem_addr = c_gnt ? bus.c_addr : d_gnt ? bus.d_addr : '0;
    assign bus.mem_wdata = c_gnt ? bus.c_wdata : d_gnt ? bus.d_wdata : '0;
    assign rd[PORT_CORE] = c_gnt && !bus.c_we;
    assign rd[PORT_DBG] = d_gnt && !bus.d_we;
    for (genvar g = 0; g < 2; g++) begin : g_resp
        mem_arb_resp #(.DW(DW)) u_resp (
            .clk(clk),
            .rst(rst),
            .rd(rd[g]),
            .mem_rdata(bus.mem_rdata),
            .rvalid(rv[g]),
            .rdata(rdt[g])
        );
    end
    assign bus.c_rvalid = rv[PORT_CORE];
    assign bus.c_rdata = rdt[PORT_CORE];
    assign bus.d_rvalid = rv[PORT_DBG];
    assign bus.d_rdata = rdt[PORT_DBG];
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port unified memory (`MEM`, combinational read, write on clock edge) between the multi-cycle core and a debug/loader port. It grants at most one access per cycle and returns read data through a registered response. It bounds core-priority starvation of the debug port and supports a debug lock for atomic multi-word sequences. It sits between the core's memory-address/write-data path and `MEM`; the core controller waits on `c_rvalid` instead of assuming same-cycle read data.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_STARVE`, 4, consecutive core grants tolerated while `d_req` is pending

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, synchronous, active-low
- `c_req`, `c_we` in 1 each: core request and write enable
- `c_addr` in AW, `c_wdata` in DW: core address and write data
- `c_gnt` out 1: core access performed this cycle
- `c_rvalid` out 1, `c_rdata` out DW: core read response
- `d_req`, `d_we`, `d_lock` in 1 each: debug request, write enable, lock
- `d_addr` in AW, `d_wdata` in DW: debug address and write data
- `d_gnt` out 1, `d_rvalid` out 1, `d_rdata` out DW: debug grant and read response
- `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out DW: to `MEM`
- `mem_rdata` in DW: from `MEM`

## Operation
- State: `st` ∈ {NORMAL, LOCKED}; `starve` counter of width clog2(MAX_STARVE+1).
- Requester contract: a requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`=1. An access completes in the cycle its `gnt`=1.
- Grant selection is combinational and evaluated in this order:
  1. LOCKED: `d_gnt`=`d_req`; `c_gnt`=0.
  2. NORMAL, `d_req` and `starve`==MAX_STARVE: debug is granted.
  3. NORMAL, `c_req`: core is granted.
  4. NORMAL, `d_req`: debug is granted.
  5. Otherwise there is no grant.
- At most one `gnt` is high per cycle.
- Memory drive: `mem_addr`/`mem_wdata` come from the granted port. `mem_we` = granted port's `we`. With no grant, all three are 0.
- `starve`:
  - Increments (saturating at MAX_STARVE) on a cycle with `c_gnt` & `d_req`.
  - Clears to 0 on `d_gnt`, or when `d_req`=0.
  - Otherwise holds.
- Lock transitions:
  - NORMAL→LOCKED when `d_gnt` & `d_lock`.
  - LOCKED→NORMAL at any edge where `d_lock`=0. The decision uses the `d_lock` value in that cycle; a grant made in that cycle still occurs.
  - In LOCKED with `d_req`=0, memory idles and the core stalls.
- Read response: on a granted read (`we`=0), `x_rdata` <= `mem_rdata` and `x_rvalid` <= 1 at that edge.
  - `x_rvalid` stays high exactly one cycle unless another read is granted back-to-back.
  - `x_rdata` holds its value between responses.
  - Writes produce no response.
- Simultaneous `c_req` and `d_req` with `starve`<MAX_STARVE: the core wins and `starve` increments.

## Timing
- Grant and memory drive: 0-cycle (combinational from `req` and `st`).
- Read data: `x_rvalid` asserts 1 cycle after the granted read cycle.
- Write: committed at the edge ending the granted cycle.
- Throughput: one access per cycle total. Back-to-back reads by one port produce consecutive `rvalid` cycles.
- Worst-case debug wait with `c_req` continuously high: MAX_STARVE cycles, granted on cycle MAX_STARVE+1.
- Reset (`rst`=0 at an edge) sets:
  - `st`=NORMAL, `starve`=0
  - `c_rvalid`=`d_rvalid`=0, `c_rdata`=`d_rdata`=0
- During a reset cycle, combinational grants still follow the inputs. Reset mid-operation drops the lock and discards any pending read response.

## Structure
- Package `mem_arb_pkg` holds:
  - the `st` enum (NORMAL, LOCKED)
  - port-id localparams PORT_CORE=0, PORT_DBG=1
  - default widths
- Sub-module `mem_arb_resp` (rdata/rvalid register with sync active-low reset), instantiated once per port.
- Grant logic, counter and lock FSM live in the top module.

## Test plan
- Core only: `c_req`=1, read at 0x10, `mem_rdata`=0xDEADBEEF → `c_gnt`=1 same cycle, next cycle `c_rvalid`=1 and `c_rdata`=0xDEADBEEF, then `c_rvalid`=0.
- Contention, MAX_STARVE=4: `c_req` and `d_req` held high → `c_gnt` on cycles 1–4, `d_gnt` on cycle 5, `starve` back to 0, core resumes on cycle 6.
- Lock: debug writes 0x100, 0x104 and 0x108 with `d_lock`=1 on the first two and `d_lock`=0 on the third, with `c_req` high throughout and a one-cycle `d_req` gap → `c_gnt`=0 through the gap, `mem_we`=0 during the gap, and the core is granted the cycle after the third write.
- Write path: debug write 0x20←0x55AA55AA, then core read 0x20 → `mem_we`=1 only in the write cycle, `d_rvalid` never asserts, `c_rdata`=0x55AA55AA.
- Reset mid-op: enter LOCKED, issue a granted read, then assert `rst`=0 at the next edge → `d_rvalid`=0, `st`=NORMAL, and a core request is granted on the first cycle after release.
- Idle: no requests → `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, both `gnt`=0.
